// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package dmem_pkg;

    localparam int WORD_W      = 32;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, synchronous (registered) read, no reset on contents.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W_WORDS = 10
) (
    input  logic                    i_clk,
    input  logic                    i_we,
    input  logic                    i_re,
    input  logic [ADDR_W_WORDS-1:0] i_addr,
    input  logic [WORD_W-1:0]       i_wdata,
    output logic [WORD_W-1:0]       o_rdata
);

    logic [WORD_W-1:0] r_mem [0:(1<<ADDR_W_WORDS)-1];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time and answers after LATENCY cycles,
// holding the pipeline via stall until the response pulse.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W_WORDS = 10,
    parameter int LATENCY      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall
);

    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    r_load_ok;
    logic                    r_err;

    logic                    w_accept;
    logic                    w_misaligned;
    logic                    w_we;
    logic                    w_re;
    logic [ADDR_W_WORDS-1:0] w_idx;
    logic [WORD_W-1:0]       w_mem_rdata;
    logic                    w_unused_addr;

    assign req_ready     = (r_state == IDLE);
    assign w_accept      = req_valid & req_ready & ~rst;
    assign w_misaligned  = is_misaligned(req_addr[1:0]);
    assign w_idx         = req_addr[ADDR_W_WORDS+1:2];
    // Upper address bits are dropped on purpose so accesses wrap over the array.
    assign w_unused_addr = ^req_addr[WORD_W-1:ADDR_W_WORDS+2];
    assign w_we          = w_accept & req_write & ~w_misaligned;
    assign w_re          = w_accept & ~req_write & ~w_misaligned;

    dmem_array #(
        .ADDR_W_WORDS(ADDR_W_WORDS)
    ) u_array (
        .i_clk  (clk),
        .i_we   (w_we),
        .i_re   (w_re),
        .i_addr (w_idx),
        .i_wdata(req_wdata),
        .o_rdata(w_mem_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_load_ok <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                // Only an aligned load forwards the array's registered read data.
                r_load_ok <= ~req_write & ~w_misaligned;
                r_err     <= w_misaligned;
            end
        end
    end

    assign resp_valid = (r_state == RESP);
    assign resp_rdata = (resp_valid && r_load_ok) ? w_mem_rdata : '0;
    assign resp_err   = resp_valid & r_err;
    assign stall      = req_valid & ~resp_valid;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY=3 and LATENCY=1) driven by directed requests,
// checked each cycle against a transaction-level model plus literal per-request expectations.
module tb_dmem_responder;

    logic             clk = 1'b0;
    logic [1:0]       rst;
    logic [1:0]       v_valid;
    logic [1:0]       v_write;
    logic [1:0][31:0] v_addr;
    logic [1:0][31:0] v_wdata;
    logic [1:0]       o_ready;
    logic [1:0]       o_rvalid;
    logic [1:0][31:0] o_rdata;
    logic [1:0]       o_err;
    logic [1:0]       o_stall;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 3 : 1;
        dmem_responder #(
            .ADDR_W_WORDS(10),
            .LATENCY     (LAT)
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .req_valid (v_valid[g]),
            .req_write (v_write[g]),
            .req_addr  (v_addr[g]),
            .req_wdata (v_wdata[g]),
            .req_ready (o_ready[g]),
            .resp_valid(o_rvalid[g]),
            .resp_rdata(o_rdata[g]),
            .resp_err  (o_err[g]),
            .stall     (o_stall[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: one pending request per instance, due in a known cycle.
    logic [31:0] m_mem [2][1024];
    bit          m_pend  [2];
    int          m_due   [2];
    logic [31:0] m_rd    [2];
    bit          m_err   [2];
    bit          m_armed [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_pend[k]  = 0;
            m_armed[k] = 0;
            m_due[k]   = 0;
        end
    end

    // Sampling at negedge with cyc=c is spec cycle c+1; an accept happens at edge c+1.
    always @(negedge clk) begin : cmp
        bit ev;
        bit rdy;
        int idx;
        for (int k = 0; k < 2; k++) begin
            rdy = !m_pend[k];
            ev  = m_pend[k] && (cyc + 1 == m_due[k]);
            if (m_armed[k]) begin
                chk($sformatf("ready%0d", k),  {31'd0, o_ready[k]},  {31'd0, rdy});
                chk($sformatf("rvalid%0d", k), {31'd0, o_rvalid[k]}, {31'd0, ev});
                chk($sformatf("stall%0d", k),  {31'd0, o_stall[k]},  {31'd0, v_valid[k] & ~ev});
                chk($sformatf("rdata%0d", k),  o_rdata[k],           ev ? m_rd[k] : 32'd0);
                chk($sformatf("err%0d", k),    {31'd0, o_err[k]},    {31'd0, ev & m_err[k]});
            end
            if (ev) m_pend[k] = 0;
            if (rst[k]) begin
                m_armed[k] = 1;
                m_pend[k]  = 0;
            end else if (m_armed[k] && rdy && v_valid[k]) begin
                idx = int'(v_addr[k][11:2]);
                m_err[k] = (v_addr[k][1:0] != 2'b00);
                m_rd[k]  = 32'd0;
                if (!m_err[k]) begin
                    if (v_write[k]) m_mem[k][idx] = v_wdata[k];
                    else            m_rd[k] = m_mem[k][idx];
                end
                m_pend[k] = 1;
                m_due[k]  = cyc + 1 + lat_of(k);
            end
        end
    end

    // Caller is positioned 1 time unit after a rising edge.
    task automatic req(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input bit exp_e, input bit hold);
        int acc;
        int got;
        bit ok;
        v_write[k] = w;
        v_addr[k]  = a;
        v_wdata[k] = d;
        v_valid[k] = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_ready[k]) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        chk("ready_wait", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        acc = cyc;
        if (!hold) v_valid[k] = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_rvalid[k]) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        chk("resp_wait", {31'd0, ok}, 32'd1);
        got = cyc + 1;
        chk("latency", got - acc, lat_of(k));
        chk("req_rdata", o_rdata[k], exp_rd);
        chk("req_err", {31'd0, o_err[k]}, {31'd0, exp_e});
        v_valid[k] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        rst     = 2'b11;
        v_valid = '0;
        v_write = '0;
        v_addr  = '0;
        v_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 2'b00;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready",  {31'd0, o_ready[k]},  32'd1);
            chk("rst_rvalid", {31'd0, o_rvalid[k]}, 32'd0);
            chk("rst_rdata",  o_rdata[k],           32'd0);
            chk("rst_stall",  {31'd0, o_stall[k]},  32'd0);
        end

        // LATENCY=3 instance
        req(0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b1);
        req(0, 1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1);
        req(0, 1'b0, 32'h0000_0042, 32'h0,         32'h0000_0000, 1'b1, 1'b1);
        req(0, 1'b1, 32'h0000_0041, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
        req(0, 1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1);
        req(0, 1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0, 1'b1);
        req(0, 1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 1'b0, 1'b0);
        req(0, 1'b1, 32'h0000_0044, 32'h0123_4567, 32'h0000_0000, 1'b0, 1'b1);
        req(0, 1'b0, 32'h0000_1044, 32'h0,         32'h0123_4567, 1'b0, 1'b1);

        // Reset while a load is waiting: no response, back to idle.
        @(posedge clk); #1;
        v_write[0] = 1'b0;
        v_addr[0]  = 32'h0000_0040;
        v_valid[0] = 1'b1;
        @(posedge clk); #1;
        chk("mid_accepted", {31'd0, o_ready[0]}, 32'd0);
        v_valid[0] = 1'b0;
        rst[0]     = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        chk("mid_rst_ready", {31'd0, o_ready[0]}, 32'd1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            pulses += int'(o_rvalid[0]);
            @(posedge clk); #1;
        end
        chk("mid_rst_no_resp", pulses, 0);
        req(0, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);

        // LATENCY=1 instance
        req(1, 1'b1, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1);
        req(1, 1'b0, 32'h0000_0000, 32'h0,         32'h1234_5678, 1'b0, 1'b1);
        req(1, 1'b1, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
        req(1, 1'b0, 32'h0000_0000, 32'h0,         32'h1234_5678, 1'b0, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
